// File: rtl/rst_seq_ctrl_pkg.sv
// Shared types and default constants for the staged reset sequencer.
package rst_seq_ctrl_pkg;

   localparam int unsigned STATE_W      = 3;
   localparam int unsigned DEF_HOLD_CYC = 32'h0000_0100;
   localparam int unsigned DEF_TMO_CYC  = 32'h0000_FFFF;

   typedef enum logic [STATE_W-1:0] {
      ST_ASSERT   = 3'd0,
      ST_WAIT_ACK = 3'd1,
      ST_GAP      = 3'd2,
      ST_DONE     = 3'd3,
      ST_ERR      = 3'd4
   } state_e;

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// Control/status bundle between the reset sequencer and its environment.
interface rst_seq_ctrl_if #(
   parameter int unsigned N_STAGE = 4
);
   localparam int unsigned STG_W = $clog2(N_STAGE);

   logic               i_soft_rst_req;
   logic [N_STAGE-1:0] i_stage_ack;
   logic [N_STAGE-1:0] o_stage_rst_n;
   logic               o_seq_busy;
   logic               o_seq_done;
   logic               o_tmo_err;
   logic [STG_W-1:0]   o_tmo_stage;

   // Environment side: issues soft requests and returns domain acks.
   modport master (
      output i_soft_rst_req, i_stage_ack,
      input  o_stage_rst_n, o_seq_busy, o_seq_done, o_tmo_err, o_tmo_stage
   );

   // Sequencer side.
   modport slave (
      input  i_soft_rst_req, i_stage_ack,
      output o_stage_rst_n, o_seq_busy, o_seq_done, o_tmo_err, o_tmo_stage
   );
endinterface

// File: rtl/rst_seq_ctrl_timer.sv
// Shared hold/timeout counter: clear, enable, and exact compare to a terminal value.
module rst_seq_ctrl_timer #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic [CNT_W-1:0] i_term,
   output logic             o_hit
);

   logic [CNT_W-1:0] r_cnt;

   // Count register; clear has priority over enable, never wraps under FSM control.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_hit = (r_cnt == i_term);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Staged reset sequencer: releases N_STAGE reset domains one at a time, each gated on the
// previous domain's ack, with hold gaps, ack timeout and soft-reset restart.
module rst_seq_ctrl
   import rst_seq_ctrl_pkg::*;
#(
   parameter int unsigned      N_STAGE  = 4,
   parameter int unsigned      CNT_W    = 16,
   parameter logic [CNT_W-1:0] HOLD_CYC = CNT_W'(DEF_HOLD_CYC),
   parameter logic [CNT_W-1:0] TMO_CYC  = CNT_W'(DEF_TMO_CYC)
) (
   input logic           i_local_clk,
   input logic           i_rst,
   rst_seq_ctrl_if.slave if_seq
);

   localparam int unsigned      STG_W     = $clog2(N_STAGE);
   localparam logic [CNT_W-1:0] HOLD_TERM = HOLD_CYC - 1'b1;
   localparam logic [CNT_W-1:0] TMO_TERM  = TMO_CYC - 1'b1;
   localparam logic [STG_W-1:0] LAST_STG  = STG_W'(N_STAGE - 1);

   state_e             r_state, w_state_d;
   logic [STG_W-1:0]   r_stg, w_stg_d, w_stg_inc;
   logic [N_STAGE-1:0] r_rst_n, w_rst_n_d;
   logic               r_busy, w_busy_d;
   logic               r_done, w_done_d;
   logic               r_err, w_err_d;
   logic [STG_W-1:0]   r_tmo_stage, w_tmo_stage_d;
   logic               w_tmr_clr, w_tmr_en, w_tmr_hit;
   logic [CNT_W-1:0]   w_tmr_term;

   // Only the ack wait uses the long timeout; assert and gap share the hold length.
   assign w_tmr_term = (r_state == ST_WAIT_ACK) ? TMO_TERM : HOLD_TERM;
   assign w_stg_inc  = r_stg + STG_W'(1);

   rst_seq_ctrl_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .i_clk  (i_local_clk),
      .i_rst  (i_rst),
      .i_clr  (w_tmr_clr),
      .i_en   (w_tmr_en),
      .i_term (w_tmr_term),
      .o_hit  (w_tmr_hit)
   );

   // State, stage index and all registered outputs.
   always_ff @(posedge i_local_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ST_ASSERT;
         r_stg       <= '0;
         r_rst_n     <= '0;
         r_busy      <= 1'b1;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_tmo_stage <= '0;
      end else begin
         r_state     <= w_state_d;
         r_stg       <= w_stg_d;
         r_rst_n     <= w_rst_n_d;
         r_busy      <= w_busy_d;
         r_done      <= w_done_d;
         r_err       <= w_err_d;
         r_tmo_stage <= w_tmo_stage_d;
      end
   end

   // Next-state and next-output logic; soft request overrides ack and timeout.
   always_comb begin
      w_state_d     = r_state;
      w_stg_d       = r_stg;
      w_rst_n_d     = r_rst_n;
      w_busy_d      = r_busy;
      w_done_d      = r_done;
      w_err_d       = r_err;
      w_tmo_stage_d = r_tmo_stage;
      w_tmr_clr     = 1'b0;
      w_tmr_en      = 1'b0;

      if (if_seq.i_soft_rst_req) begin
         w_state_d     = ST_ASSERT;
         w_stg_d       = '0;
         w_rst_n_d     = '0;
         w_busy_d      = 1'b1;
         w_done_d      = 1'b0;
         w_err_d       = 1'b0;
         w_tmo_stage_d = '0;
         w_tmr_clr     = 1'b1;
      end else begin
         case (r_state)
            ST_ASSERT: begin
               if (w_tmr_hit) begin
                  w_rst_n_d[0] = 1'b1;
                  w_stg_d      = '0;
                  w_tmr_clr    = 1'b1;
                  w_state_d    = ST_WAIT_ACK;
               end else begin
                  w_tmr_en = 1'b1;
               end
            end
            ST_WAIT_ACK: begin
               if (if_seq.i_stage_ack[r_stg]) begin
                  w_tmr_clr = 1'b1;
                  if (r_stg == LAST_STG) begin
                     w_state_d = ST_DONE;
                     w_done_d  = 1'b1;
                     w_busy_d  = 1'b0;
                  end else begin
                     w_state_d = ST_GAP;
                  end
               end else if (w_tmr_hit) begin
                  w_state_d     = ST_ERR;
                  w_err_d       = 1'b1;
                  w_tmo_stage_d = r_stg;
                  w_busy_d      = 1'b0;
                  w_rst_n_d     = '0;
               end else begin
                  w_tmr_en = 1'b1;
               end
            end
            ST_GAP: begin
               if (w_tmr_hit) begin
                  w_stg_d              = w_stg_inc;
                  w_rst_n_d[w_stg_inc] = 1'b1;
                  w_tmr_clr            = 1'b1;
                  w_state_d            = ST_WAIT_ACK;
               end else begin
                  w_tmr_en = 1'b1;
               end
            end
            default: ;  // ST_DONE and ST_ERR hold until soft request or i_rst
         endcase
      end
   end

   assign if_seq.o_stage_rst_n = r_rst_n;
   assign if_seq.o_seq_busy    = r_busy;
   assign if_seq.o_seq_done    = r_done;
   assign if_seq.o_tmo_err     = r_err;
   assign if_seq.o_tmo_stage   = r_tmo_stage;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with N_STAGE=4, HOLD_CYC=4, TMO_CYC=8.
module tb_rst_seq_ctrl;

   logic        clk;
   logic        rst;
   int unsigned edge_cnt;
   int unsigned n_cmp;
   int unsigned n_err;

   rst_seq_ctrl_if #(.N_STAGE(4)) u_if ();

   rst_seq_ctrl #(
      .N_STAGE  (4),
      .CNT_W    (16),
      .HOLD_CYC (16'd4),
      .TMO_CYC  (16'd8)
   ) u_dut (
      .i_local_clk (clk),
      .i_rst       (rst),
      .if_seq      (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        do_rst;
      logic [3:0]  ack;
      int unsigned edge_n;
      logic [3:0]  rst_n;
      logic        busy;
      logic        done;
      logic        err;
      logic [1:0]  stg;
   } vec_t;

   vec_t vecs[19];

   task automatic check(input string name, input logic [3:0] e_rst_n, input logic e_busy,
                        input logic e_done, input logic e_err, input logic [1:0] e_stg);
      logic [8:0] got;
      logic [8:0] exp;
      got = {u_if.o_stage_rst_n, u_if.o_seq_busy, u_if.o_seq_done, u_if.o_tmo_err,
             u_if.o_tmo_stage};
      exp = {e_rst_n, e_busy, e_done, e_err, e_stg};
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @edge %0d: got rst_n=%b busy=%b done=%b err=%b stg=%0d, want rst_n=%b busy=%b done=%b err=%b stg=%0d",
                  name, edge_cnt, got[8:5], got[4], got[3], got[2], got[1:0],
                  e_rst_n, e_busy, e_done, e_err, e_stg);
      end
   endtask

   // Called from just after a posedge; leaves us #1 after the last edge stepped.
   task automatic step(input int unsigned n);
      repeat (n) @(posedge clk);
      edge_cnt += n;
      #1;
   endtask

   // Synchronous-looking reset pulse; the next posedge after return is edge 1.
   task automatic do_reset(input logic [3:0] ack);
      u_if.i_stage_ack    = ack;
      u_if.i_soft_rst_req = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      edge_cnt = 0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      edge_cnt = 0;
      rst = 1'b1;
      u_if.i_soft_rst_req = 1'b0;
      u_if.i_stage_ack = 4'b0000;

      // Test 1: all acks high, stages released at 4,9,14,19; done at 20.
      vecs[0]  = '{1'b1, 4'b1111, 0,  4'b0000, 1'b1, 1'b0, 1'b0, 2'd0};
      vecs[1]  = '{1'b0, 4'b1111, 3,  4'b0000, 1'b1, 1'b0, 1'b0, 2'd0};
      vecs[2]  = '{1'b0, 4'b1111, 4,  4'b0001, 1'b1, 1'b0, 1'b0, 2'd0};
      vecs[3]  = '{1'b0, 4'b1111, 8,  4'b0001, 1'b1, 1'b0, 1'b0, 2'd0};
      vecs[4]  = '{1'b0, 4'b1111, 9,  4'b0011, 1'b1, 1'b0, 1'b0, 2'd0};
      vecs[5]  = '{1'b0, 4'b1111, 13, 4'b0011, 1'b1, 1'b0, 1'b0, 2'd0};
      vecs[6]  = '{1'b0, 4'b1111, 14, 4'b0111, 1'b1, 1'b0, 1'b0, 2'd0};
      vecs[7]  = '{1'b0, 4'b1111, 19, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0};
      vecs[8]  = '{1'b0, 4'b1111, 20, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0};
      vecs[9]  = '{1'b0, 4'b1111, 30, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0};
      // Test 2: ack[1] stuck low, timeout 8 cycles after rst_n[1] at edge 9.
      vecs[10] = '{1'b1, 4'b1101, 0,  4'b0000, 1'b1, 1'b0, 1'b0, 2'd0};
      vecs[11] = '{1'b0, 4'b1101, 9,  4'b0011, 1'b1, 1'b0, 1'b0, 2'd0};
      vecs[12] = '{1'b0, 4'b1101, 16, 4'b0011, 1'b1, 1'b0, 1'b0, 2'd0};
      vecs[13] = '{1'b0, 4'b1101, 17, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1};
      vecs[14] = '{1'b0, 4'b1101, 40, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1};
      // Other-stage acks ignored: ack[0] low stalls at stage 0 even with others high.
      vecs[15] = '{1'b1, 4'b1110, 0,  4'b0000, 1'b1, 1'b0, 1'b0, 2'd0};
      vecs[16] = '{1'b0, 4'b1110, 11, 4'b0001, 1'b1, 1'b0, 1'b0, 2'd0};
      vecs[17] = '{1'b0, 4'b1110, 12, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0};
      vecs[18] = '{1'b0, 4'b1110, 20, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0};

      // Reset state before any clock edge.
      #1;
      check("por", 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0);

      for (int i = 0; i < 19; i++) begin
         if (vecs[i].do_rst) begin
            do_reset(vecs[i].ack);
         end else begin
            u_if.i_stage_ack = vecs[i].ack;
            if (vecs[i].edge_n > edge_cnt) step(vecs[i].edge_n - edge_cnt);
         end
         check($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].busy, vecs[i].done,
               vecs[i].err, vecs[i].stg);
      end

      // Test 3 + 5a: soft request while waiting on stage 2, with ack[2] arriving same cycle.
      do_reset(4'b1011);
      step(14);
      check("t3_stg2_rel", 4'b0111, 1'b1, 1'b0, 1'b0, 2'd0);
      step(1);
      check("t3_stg2_wait", 4'b0111, 1'b1, 1'b0, 1'b0, 2'd0);
      u_if.i_soft_rst_req = 1'b1;
      u_if.i_stage_ack    = 4'b1111;
      step(1);
      u_if.i_soft_rst_req = 1'b0;
      check("t3_soft_wins", 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0);
      step(3);
      check("t3_hold", 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0);
      step(1);
      check("t3_rel0", 4'b0001, 1'b1, 1'b0, 1'b0, 2'd0);
      step(15);
      check("t3_rel3", 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0);
      step(1);
      check("t3_done", 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0);

      // Test 4: async reset mid-gap, checked before any clock edge.
      do_reset(4'b1111);
      step(6);
      check("t4_gap", 4'b0001, 1'b1, 1'b0, 1'b0, 2'd0);
      #3;
      rst = 1'b1;
      #1;
      check("t4_async", 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0);
      #1;
      rst = 1'b0;
      edge_cnt = 0;
      step(3);
      check("t4_hold", 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0);
      step(1);
      check("t4_rel0", 4'b0001, 1'b1, 1'b0, 1'b0, 2'd0);

      // Test 5b: soft request clears a timeout error.
      do_reset(4'b1101);
      step(17);
      check("t5_err", 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1);
      u_if.i_soft_rst_req = 1'b1;
      step(1);
      u_if.i_soft_rst_req = 1'b0;
      check("t5_clr", 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0);
      step(4);
      check("t5_rel0", 4'b0001, 1'b1, 1'b0, 1'b0, 2'd0);

      // Test 6: ack removal after done is ignored.
      do_reset(4'b1111);
      step(20);
      check("t6_done", 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0);
      u_if.i_stage_ack = 4'b1110;
      step(5);
      check("t6_ack0_drop", 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0);
      u_if.i_stage_ack = 4'b0000;
      step(3);
      check("t6_all_drop", 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
